i2c_slave_mem: RTL
==================

I2C_SLAVE_MEM -- requirements
Module: i2c_slave_mem

Interface
REQ-001 The block SHALL have parameter MEM_DEPTH, default 128, meaning the number of byte locations, indexed by the 7-bit bus address.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth on scl and sda.
REQ-003 The block SHALL have port clk, input, 1 bit: the system clock, at least 16x the scl frequency.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port scl, inout tri, 1 bit: the I2C clock, never driven by this block (no clock stretching).
REQ-006 The block SHALL have port sda, inout tri, 1 bit: the I2C data line, open-drain, either driven 1'b0 or released to 1'bz; the bench supplies the pull-up.
REQ-007 The block SHALL have port busy, output, 1 bit: high from START detection until STOP detection.
REQ-008 The block SHALL have port done, output, 1 bit: a one-clk pulse on STOP detection when busy was high.
REQ-009 The block SHALL have port wrStrobe, output, 1 bit: a one-clk pulse when a received data byte is committed to memory.
REQ-010 The block SHALL have port memAddr, output, 7 bits: the current memory pointer.

Function
REQ-011 scl and sda SHALL pass through SYNC_STAGES flops, plus one history flop for edge detection; all bus events are therefore acted on SYNC_STAGES+1 clk cycles after the pin changes.
REQ-012 START = synced sda falling while synced scl high; STOP = synced sda rising while synced scl high; both SHALL be recognised in every state.
REQ-013 The states SHALL be IDLE, ADDR, ACK_ADDR, WR_DATA, ACK_DATA, RD_DATA, MACK and WAIT_STOP.
REQ-014 START SHALL go to ADDR from any state, including a repeated START, and clear the bit counter and shift register.
REQ-015 STOP SHALL go to IDLE from any state, release sda, drop busy and pulse done.
REQ-016 ADDR SHALL shift sda in MSB first on each scl rising edge; after 8 bits, {addr[6:0], rw} is complete, memAddr <= addr, and the next scl falling edge goes to ACK_ADDR.
REQ-017 In ACK_ADDR the block SHALL drive sda low, since every address is acknowledged, and hold it low until the next scl falling edge.
REQ-018 At the end of ACK_ADDR the block SHALL go to WR_DATA if rw=0, or to RD_DATA if rw=1, and SHALL drive mem[memAddr][7] during the same falling edge.
REQ-019 WR_DATA SHALL sample 8 bits on scl rising edges; at the 8th rising edge, mem[memAddr] <= byte, and wrStrobe pulses.
REQ-020 On the following scl falling edge WR_DATA SHALL go to ACK_DATA, which drives sda low for one scl period.
REQ-021 At the end of ACK_DATA the block SHALL return to WR_DATA, and the pointer SHALL update per REQ-030/031.
REQ-022 RD_DATA SHALL present bit 7..0 of the read byte on sda, changing only on scl falling edges; a 1 bit releases sda and a 0 bit drives it low.
REQ-023 After the 8th bit, the block SHALL release sda on the scl falling edge and enter MACK.
REQ-024 MACK SHALL sample sda on the scl rising edge; 0 (ACK) updates the pointer and returns to RD_DATA, driving the new byte's MSB on the next falling edge; 1 (NACK) goes to WAIT_STOP.
REQ-025 WAIT_STOP SHALL keep sda released and ignore scl edges until START or STOP occurs.
REQ-026 In IDLE, scl and sda edges other than START SHALL be ignored.
REQ-027 The pointer SHALL be 7 bits and wrap from 7'h7F to 7'h00.
REQ-028 If a STOP or START arrives mid-byte, the partial byte SHALL be discarded, with no memory write and no wrStrobe.
REQ-029 sda SHALL never be driven low while the synced scl is high, except when holding an ACK or data bit that was set up on the preceding falling edge.

Configuration
REQ-030 With I2C_SLV_AUTOINC_EN defined, the pointer SHALL increment by one, with wrap, after each acknowledged data byte in both directions.
REQ-031 Without I2C_SLV_AUTOINC_EN, the pointer SHALL stay at the address from ADDR; repeated writes overwrite one location and repeated reads return the same byte.

Reset
REQ-032 rst low SHALL asynchronously force the following: state=IDLE, sda released, busy=0, done=0, wrStrobe=0, memAddr=0, all mem bytes=8'h00, and synchronizer flops=1.
REQ-033 Reset asserted mid-transaction SHALL release sda within the same clk cycle; after rst rises, the block SHALL wait for a fresh START.

Verification
REQ-034 The bench SHALL cover a write: START, 7'h12+W, 8'hA5, STOP -> two ACKs; one wrStrobe; mem[7'h12]=8'hA5; done pulses once; busy high throughout.
REQ-035 The bench SHALL cover a read-back: START, 7'h12+R, master NACK, STOP -> slave drives 8'hA5 MSB first; the block enters WAIT_STOP and then IDLE on STOP.
REQ-036 The bench SHALL cover auto-increment, with I2C_SLV_AUTOINC_EN defined: write 7'h7F with bytes 8'h11 and 8'h22 -> mem[7'h7F]=8'h11 and mem[7'h00]=8'h22; without the macro, mem[7'h7F]=8'h22.
REQ-037 The bench SHALL cover a STOP after 4 data bits -> no wrStrobe; memory unchanged; state IDLE; sda released.
REQ-038 The bench SHALL cover a repeated START after the write address -> the block returns to ADDR; the new read of 7'h12 returns 8'hA5.
REQ-039 The bench SHALL cover rst pulsed low during RD_DATA with sda held low -> sda released immediately; all mem bytes read 8'h00 afterwards.

Source files
------------

// File: rtl/i2c_slave_mem.sv
// I2C slave with a 128-byte register file addressed by the 7-bit bus address (no clock stretching).
// Define I2C_SLV_AUTOINC_EN to advance the pointer after every acknowledged data byte.
module i2c_slave_mem #(
   parameter int MEM_DEPTH   = 128,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   inout  tri         scl,
   inout  tri         sda,
   output logic       busy,
   output logic       done,
   output logic       wrStrobe,
   output logic [6:0] memAddr
);

`ifdef I2C_SLV_AUTOINC_EN
   localparam logic [6:0] PTR_STEP = 7'd1;
`else
   localparam logic [6:0] PTR_STEP = 7'd0;
`endif

   typedef enum logic [2:0] {
      IDLE, ADDR, ACK_ADDR, WR_DATA, ACK_DATA, RD_DATA, MACK, WAIT_STOP
   } state_t;

   state_t                   state;
   logic [SYNC_STAGES-1:0]   scl_sync, sda_sync;
   logic                     scl_hist, sda_hist;
   logic                     scl_s, sda_s;
   logic                     scl_rise, scl_fall, start_det, stop_det;
   logic [7:0]               mem [MEM_DEPTH];
   logic [7:0]               shreg;
   logic [7:0]               rd_byte;
   logic [3:0]               bit_cnt;
   logic                     rw;
   logic                     sda_oe;

   // Open-drain: only ever pull low or let the external pull-up win
   assign sda = sda_oe ? 1'b0 : 1'bz;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_hist <= 1'b1;
         sda_hist <= 1'b1;
      end else begin
         scl_sync[0] <= scl;
         sda_sync[0] <= sda;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            scl_sync[i] <= scl_sync[i-1];
            sda_sync[i] <= sda_sync[i-1];
         end
         scl_hist <= scl_sync[SYNC_STAGES-1];
         sda_hist <= sda_sync[SYNC_STAGES-1];
      end
   end

   assign scl_s     = scl_sync[SYNC_STAGES-1];
   assign sda_s     = sda_sync[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_hist;
   assign scl_fall  = ~scl_s & scl_hist;
   assign start_det = scl_s & scl_hist & ~sda_s & sda_hist;
   assign stop_det  = scl_s & scl_hist & sda_s & ~sda_hist;
   assign rd_byte   = mem[memAddr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         sda_oe   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         wrStrobe <= 1'b0;
         memAddr  <= '0;
         shreg    <= '0;
         bit_cnt  <= '0;
         rw       <= 1'b0;
         for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= 8'h00;
      end else begin
         done     <= 1'b0;
         wrStrobe <= 1'b0;
         if (start_det) begin
            state   <= ADDR;
            bit_cnt <= '0;
            shreg   <= '0;
            sda_oe  <= 1'b0;
            busy    <= 1'b1;
         end else if (stop_det) begin
            state  <= IDLE;
            sda_oe <= 1'b0;
            busy   <= 1'b0;
            done   <= busy;
         end else begin
            case (state)
               ADDR: begin
                  if (scl_rise && bit_cnt < 4'd8) begin
                     shreg   <= {shreg[6:0], sda_s};
                     bit_cnt <= bit_cnt + 4'd1;
                     if (bit_cnt == 4'd7) begin
                        memAddr <= shreg[6:0];
                        rw      <= sda_s;
                     end
                  end else if (scl_fall && bit_cnt == 4'd8) begin
                     state  <= ACK_ADDR;
                     sda_oe <= 1'b1;
                  end
               end
               ACK_ADDR: begin
                  if (scl_fall) begin
                     if (rw) begin
                        state   <= RD_DATA;
                        shreg   <= {rd_byte[6:0], 1'b0};
                        sda_oe  <= ~rd_byte[7];
                        bit_cnt <= 4'd1;
                     end else begin
                        state   <= WR_DATA;
                        sda_oe  <= 1'b0;
                        bit_cnt <= '0;
                     end
                  end
               end
               WR_DATA: begin
                  // Commit on the 8th rising edge; a START/STOP before then drops the byte
                  if (scl_rise && bit_cnt < 4'd8) begin
                     shreg   <= {shreg[6:0], sda_s};
                     bit_cnt <= bit_cnt + 4'd1;
                     if (bit_cnt == 4'd7) begin
                        mem[memAddr] <= {shreg[6:0], sda_s};
                        wrStrobe     <= 1'b1;
                     end
                  end else if (scl_fall && bit_cnt == 4'd8) begin
                     state  <= ACK_DATA;
                     sda_oe <= 1'b1;
                  end
               end
               ACK_DATA: begin
                  if (scl_fall) begin
                     state   <= WR_DATA;
                     sda_oe  <= 1'b0;
                     bit_cnt <= '0;
                     memAddr <= memAddr + PTR_STEP;
                  end
               end
               RD_DATA: begin
                  // bit_cnt counts bits already on the wire; 0 means reload after a master ACK
                  if (scl_fall) begin
                     if (bit_cnt == 4'd8) begin
                        state  <= MACK;
                        sda_oe <= 1'b0;
                     end else if (bit_cnt == 4'd0) begin
                        shreg   <= {rd_byte[6:0], 1'b0};
                        sda_oe  <= ~rd_byte[7];
                        bit_cnt <= 4'd1;
                     end else begin
                        shreg   <= {shreg[6:0], 1'b0};
                        sda_oe  <= ~shreg[7];
                        bit_cnt <= bit_cnt + 4'd1;
                     end
                  end
               end
               MACK: begin
                  if (scl_rise) begin
                     if (!sda_s) begin
                        state   <= RD_DATA;
                        bit_cnt <= '0;
                        memAddr <= memAddr + PTR_STEP;
                     end else begin
                        state <= WAIT_STOP;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
